// File: rtl/pipe_bus_arbiter_if.sv
// pipe_bus_arbiter_if: external memory bus between the arbiter (master) and memory (slave)
interface pipe_bus_arbiter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  modport master (output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, input bus_rdata, bus_ack);
  modport slave  (input bus_req, bus_we, bus_addr, bus_sel, bus_wdata, output bus_rdata, bus_ack);
endinterface

// File: rtl/pipe_bus_arbiter.sv
// pipe_bus_arbiter: shares one memory bus between fetch and load/store and drives the pipeline stall vector
module pipe_bus_arbiter #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_ce,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_inst,
  input  logic               mem_ce,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [3:0]         mem_sel,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               flush,
  output logic               mem_busy,
  output logic [5:0]         stall,
  output logic               bus_err_o,
  pipe_bus_arbiter_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, IF_BUS, IF_DRAIN, MEM_BUS, MEM_DONE} state_t;
  state_t state, nstate;
  logic [31:0] buf_data, tag;
  logic valid, hit, stallreq_mem, stallreq_if, fill, consume;
  logic [CW-1:0] cnt, cnt_n;
  assign hit = valid && tag == if_addr;
  assign stallreq_mem = mem_ce && state != MEM_DONE;
  assign stallreq_if = if_ce && !hit;
  assign fill = state == IF_BUS && bus.bus_ack && !flush;
  assign consume = hit && if_ce && !stall[1];
  // cnt holds the index of the current MEM_BUS cycle, saturating at the timeout
  assign cnt_n = nstate != MEM_BUS ? '0 : cnt == CW'(MEM_TIMEOUT) ? cnt : cnt + CW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:     nstate = flush ? IDLE : mem_ce ? MEM_BUS : (if_ce && !hit) ? IF_BUS : IDLE;
      IF_BUS:   nstate = bus.bus_ack ? IDLE : flush ? IF_DRAIN : IF_BUS;
      IF_DRAIN: nstate = bus.bus_ack ? IDLE : IF_DRAIN;
      MEM_BUS:  nstate = bus.bus_ack ? MEM_DONE : MEM_BUS;
      MEM_DONE: nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end
  always_comb begin
    stall = (!rst || flush) ? 6'b000000 : stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
            (stallreq_id || stallreq_if) ? 6'b000111 : 6'b000000;
    mem_busy = state == MEM_BUS;
    if_inst = buf_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bus_req <= 1'b0;
      bus.bus_we <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_sel <= '0;
      bus.bus_wdata <= '0;
      mem_rdata <= '0;
      buf_data <= '0;
      tag <= '0;
      valid <= 1'b0;
      cnt <= '0;
      bus_err_o <= 1'b0;
    end else begin
      cnt <= cnt_n;
      bus_err_o <= cnt_n == CW'(MEM_TIMEOUT) && cnt != CW'(MEM_TIMEOUT);
      if (state == IDLE && nstate == MEM_BUS) begin
        bus.bus_req <= 1'b1;
        bus.bus_we <= mem_we;
        bus.bus_addr <= mem_addr;
        bus.bus_sel <= mem_sel;
        bus.bus_wdata <= mem_wdata;
      end else if (state == IDLE && nstate == IF_BUS) begin
        bus.bus_req <= 1'b1;
        bus.bus_we <= 1'b0;
        bus.bus_addr <= if_addr;
        bus.bus_sel <= 4'hF;
        bus.bus_wdata <= '0;
      end else if (bus.bus_ack && (state == IF_BUS || state == IF_DRAIN || state == MEM_BUS)) begin
        bus.bus_req <= 1'b0;
      end
      if (state == MEM_BUS && bus.bus_ack && !bus.bus_we) mem_rdata <= bus.bus_rdata;
      // a fill wins over invalidation; a flush in MEM_BUS cannot occur
      if (fill) begin
        buf_data <= bus.bus_rdata;
        tag <= bus.bus_addr;
        valid <= 1'b1;
      end else if (consume || (flush && state != MEM_BUS)) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_bus_arbiter.sv
// tb_pipe_bus_arbiter: directed self-checking bench for pipe_bus_arbiter (MEM_TIMEOUT=4)
module tb_pipe_bus_arbiter;
  logic clk = 0, rst = 0;
  logic if_ce = 0, mem_ce = 0, mem_we = 0, stallreq_id = 0, stallreq_ex = 0, flush = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_sel = 0;
  logic [31:0] if_inst, mem_rdata;
  logic mem_busy, bus_err_o;
  logic [5:0] stall;
  int checks = 0, errors = 0;
  logic [2:0] pv [3] = '{3'b100, 3'b110, 3'b011};
  logic [5:0] pe [3] = '{6'b000111, 6'b001111, 6'b000000};
  pipe_bus_arbiter_if bus ();
  pipe_bus_arbiter #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .flush(flush), .mem_busy(mem_busy), .stall(stall),
    .bus_err_o(bus_err_o), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    assert (!(rst && flush && mem_busy)) else $error("FAIL flush_while_busy flush=%b mem_busy=%b", flush, mem_busy);
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task adv;
    @(posedge clk);
    #1;
  endtask
  task mid;
    @(negedge clk);
  endtask
  task test_reset;
    rst = 0; if_ce = 1; if_addr = 32'h40;
    mid;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    checks++; if (bus.bus_req !== 1'b0 || bus.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus got req=%b addr=%h exp req=0 addr=0", bus.bus_req, bus.bus_addr); end
    checks++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_out got inst=%h rdata=%h err=%b exp 0", if_inst, mem_rdata, bus_err_o); end
    adv; rst = 1;
    mid;
    checks++; if (stall !== 6'b000111 || bus.bus_req !== 1'b0) begin errors++; $display("FAIL post_reset got stall=%b req=%b exp 000111/0", stall, bus.bus_req); end
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h40 || bus.bus_sel !== 4'hF || bus.bus_we !== 1'b0)
      begin errors++; $display("FAIL first_fetch got req=%b addr=%h sel=%h we=%b exp 1/40/f/0", bus.bus_req, bus.bus_addr, bus.bus_sel, bus.bus_we); end
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL first_fetch_stall got=%b exp=000111", stall); end
    bus.bus_ack = 1; bus.bus_rdata = 32'h11111111;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h11111111 || stall !== 6'b000000) begin errors++; $display("FAIL first_deliver got inst=%h stall=%b exp 11111111/000000", if_inst, stall); end
    adv; if_ce = 0;
  endtask
  task test_fetch;
    if_ce = 1; if_addr = 32'h100;
    mid;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL fetch_req_stall got=%b exp=000111", stall); end
    adv;
    for (int i = 0; i < 3; i++) begin
      mid;
      checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h100 || stall !== 6'b000111)
        begin errors++; $display("FAIL fetch_wait%0d got req=%b addr=%h stall=%b exp 1/100/000111", i, bus.bus_req, bus.bus_addr, stall); end
      adv;
    end
    bus.bus_ack = 1; bus.bus_rdata = 32'h3C010001;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h3C010001 || stall !== 6'b000000) begin errors++; $display("FAIL fetch_deliver got inst=%h stall=%b exp 3c010001/000000", if_inst, stall); end
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got=%b exp=0", bus.bus_req); end
    adv;
    mid;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL fetch_invalidate got stall=%b exp=000111", stall); end
    if_ce = 0;
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL fetch_idle got req=%b exp=0", bus.bus_req); end
  endtask
  task test_stall_priority;
    for (int i = 0; i < 3; i++) begin
      adv; {stallreq_id, stallreq_ex, flush} = pv[i];
      mid;
      checks++; if (stall !== pe[i]) begin errors++; $display("FAIL stall_prio%0d got=%b exp=%b", i, stall, pe[i]); end
    end
    adv; {stallreq_id, stallreq_ex, flush} = 3'b000;
  endtask
  task test_mem_priority;
    if_ce = 1; if_addr = 32'h104; mem_ce = 1; mem_we = 0; mem_addr = 32'h80; mem_sel = 4'hF;
    mid;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_req_stall got=%b exp=011111", stall); end
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h80 || bus.bus_we !== 1'b0 || mem_busy !== 1'b1)
      begin errors++; $display("FAIL prio_mem_first got req=%b addr=%h we=%b busy=%b exp 1/80/0/1", bus.bus_req, bus.bus_addr, bus.bus_we, mem_busy); end
    adv; bus.bus_ack = 1; bus.bus_rdata = 32'hDEADBEEF;
    mid;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_ack_stall got=%b exp=011111", stall); end
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (mem_rdata !== 32'hDEADBEEF || stall !== 6'b000111 || mem_busy !== 1'b0 || bus.bus_req !== 1'b0)
      begin errors++; $display("FAIL prio_mem_done got rdata=%h stall=%b busy=%b req=%b exp deadbeef/000111/0/0", mem_rdata, stall, mem_busy, bus.bus_req); end
    adv; mem_ce = 0;
    mid;
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL prio_gap got req=%b exp=0", bus.bus_req); end
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h104) begin errors++; $display("FAIL prio_if_after got req=%b addr=%h exp 1/104", bus.bus_req, bus.bus_addr); end
    bus.bus_ack = 1; bus.bus_rdata = 32'h22222222;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h22222222 || stall !== 6'b000000) begin errors++; $display("FAIL prio_if_deliver got inst=%h stall=%b exp 22222222/000000", if_inst, stall); end
    adv; if_ce = 0;
  endtask
  task test_stall_hold;
    if_ce = 1; if_addr = 32'h200; stallreq_ex = 1;
    mid;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL hold_req_stall got=%b exp=001111", stall); end
    adv; bus.bus_ack = 1; bus.bus_rdata = 32'h33333333;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h200) begin errors++; $display("FAIL hold_fetch got req=%b addr=%h exp 1/200", bus.bus_req, bus.bus_addr); end
    adv; bus.bus_ack = 0;
    for (int i = 0; i < 2; i++) begin
      mid;
      checks++; if (stall !== 6'b001111 || bus.bus_req !== 1'b0 || if_inst !== 32'h33333333)
        begin errors++; $display("FAIL hold_buf%0d got stall=%b req=%b inst=%h exp 001111/0/33333333", i, stall, bus.bus_req, if_inst); end
      adv;
    end
    stallreq_ex = 0;
    mid;
    checks++; if (stall !== 6'b000000 || if_inst !== 32'h33333333) begin errors++; $display("FAIL hold_release got stall=%b inst=%h exp 000000/33333333", stall, if_inst); end
    adv; if_ce = 0;
    mid;
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL hold_no_refetch got req=%b exp=0", bus.bus_req); end
  endtask
  task test_flush;
    if_ce = 1; if_addr = 32'h300;
    adv; flush = 1;
    mid;
    checks++; if (stall !== 6'b000000 || bus.bus_req !== 1'b1) begin errors++; $display("FAIL flush_cycle got stall=%b req=%b exp 000000/1", stall, bus.bus_req); end
    adv; flush = 0; if_addr = 32'h400;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h300 || stall !== 6'b000111)
      begin errors++; $display("FAIL flush_drain got req=%b addr=%h stall=%b exp 1/300/000111", bus.bus_req, bus.bus_addr, stall); end
    bus.bus_ack = 1; bus.bus_rdata = 32'h44444444;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h33333333 || stall !== 6'b000111 || bus.bus_req !== 1'b0)
      begin errors++; $display("FAIL flush_discard got inst=%h stall=%b req=%b exp 33333333/000111/0", if_inst, stall, bus.bus_req); end
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h400) begin errors++; $display("FAIL flush_refetch got req=%b addr=%h exp 1/400", bus.bus_req, bus.bus_addr); end
    bus.bus_ack = 1; bus.bus_rdata = 32'h55555555;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h55555555 || stall !== 6'b000000) begin errors++; $display("FAIL flush_new_inst got inst=%h stall=%b exp 55555555/000000", if_inst, stall); end
    adv; if_ce = 0;
  endtask
  task test_timeout;
    mem_ce = 1; mem_we = 1; mem_addr = 32'h90; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
    adv;
    for (int w = 1; w <= 6; w++) begin
      mid;
      checks++; if (bus_err_o !== (w == 4)) begin errors++; $display("FAIL timeout_err_w%0d got=%b exp=%b", w, bus_err_o, w == 4); end
      checks++; if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1 || bus.bus_wdata !== 32'h12345678 || bus.bus_sel !== 4'b0011 || mem_busy !== 1'b1)
        begin errors++; $display("FAIL timeout_hold_w%0d got req=%b we=%b wdata=%h sel=%b busy=%b", w, bus.bus_req, bus.bus_we, bus.bus_wdata, bus.bus_sel, mem_busy); end
      adv;
    end
    bus.bus_ack = 1;
    mid;
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL timeout_err_late got=%b exp=0", bus_err_o); end
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (mem_rdata !== 32'hDEADBEEF || stall !== 6'b000000 || bus.bus_req !== 1'b0)
      begin errors++; $display("FAIL timeout_done got rdata=%h stall=%b req=%b exp deadbeef/000000/0", mem_rdata, stall, bus.bus_req); end
    adv; mem_ce = 0;
  endtask
  task test_back_to_back;
    mem_ce = 1; mem_we = 0; mem_addr = 32'hA0; mem_sel = 4'hF;
    adv; bus.bus_ack = 1; bus.bus_rdata = 32'h66666666;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'hA0) begin errors++; $display("FAIL b2b_load got req=%b addr=%h exp 1/a0", bus.bus_req, bus.bus_addr); end
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (mem_rdata !== 32'h66666666 || stall !== 6'b000000) begin errors++; $display("FAIL b2b_load_done got rdata=%h stall=%b exp 66666666/000000", mem_rdata, stall); end
    adv; mem_we = 1; mem_addr = 32'hB0; mem_wdata = 32'h77777777; mem_sel = 4'b1100;
    mid;
    checks++; if (stall !== 6'b011111 || bus.bus_req !== 1'b0) begin errors++; $display("FAIL b2b_idle got stall=%b req=%b exp 011111/0", stall, bus.bus_req); end
    adv; bus.bus_ack = 1;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1 || bus.bus_addr !== 32'hB0 || bus.bus_wdata !== 32'h77777777 || bus.bus_sel !== 4'b1100)
      begin errors++; $display("FAIL b2b_store got req=%b we=%b addr=%h wdata=%h sel=%b", bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_sel); end
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (mem_rdata !== 32'h66666666 || stall !== 6'b000000) begin errors++; $display("FAIL b2b_store_done got rdata=%h stall=%b exp 66666666/000000", mem_rdata, stall); end
    adv; mem_ce = 0; mem_we = 0;
  endtask
  task test_reset_mid;
    if_ce = 1; if_addr = 32'h500;
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1) begin errors++; $display("FAIL rmid_start got req=%b exp=1", bus.bus_req); end
    rst = 0;
    #1;
    checks++; if (bus.bus_req !== 1'b0 || stall !== 6'b000000) begin errors++; $display("FAIL rmid_abort got req=%b stall=%b exp 0/000000", bus.bus_req, stall); end
    adv; rst = 1; if_ce = 0; bus.bus_ack = 1; bus.bus_rdata = 32'h88888888;
    mid;
    checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL rmid_stale_ack got req=%b exp=0", bus.bus_req); end
    adv; bus.bus_ack = 0; if_ce = 1;
    mid;
    checks++; if (stall !== 6'b000111 || if_inst !== 32'h0) begin errors++; $display("FAIL rmid_no_fill got stall=%b inst=%h exp 000111/0", stall, if_inst); end
    adv;
    mid;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h500) begin errors++; $display("FAIL rmid_refetch got req=%b addr=%h exp 1/500", bus.bus_req, bus.bus_addr); end
    bus.bus_ack = 1; bus.bus_rdata = 32'h99999999;
    adv; bus.bus_ack = 0;
    mid;
    checks++; if (if_inst !== 32'h99999999 || stall !== 6'b000000) begin errors++; $display("FAIL rmid_deliver got inst=%h stall=%b exp 99999999/000000", if_inst, stall); end
    adv; if_ce = 0;
  endtask
  initial begin
    bus.bus_ack = 0;
    bus.bus_rdata = 0;
    test_reset;
    test_fetch;
    test_stall_priority;
    test_mem_priority;
    test_stall_hold;
    test_flush;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_bus_arbiter.md
Name: pipe_bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and load/store (MEM).
- Generates the 6-bit pipeline stall vector consumed by every pipeline register: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- MEM has priority over IF because it is the older instruction.
- Holds a fetched instruction in a one-entry tagged buffer when the pipeline cannot yet accept it.

Parameters:
- MEM_TIMEOUT, 255, cycles in MEM_BUS before bus_err_o pulses; the access still waits for ack.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_ce  in  1  fetch request.
- if_addr  in  32  fetch address, word aligned.
- if_inst  out  32  fetched instruction; valid when the fetch stall is released.
- mem_ce  in  1  load/store request.
- mem_we  in  1  1 = store.
- mem_addr  in  32  data address.
- mem_sel  in  4  byte enables.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data.
- stallreq_id  in  1  ID stage hazard stall request.
- stallreq_ex  in  1  EX stage multi-cycle stall request.
- flush  in  1  exception/branch flush pulse.
- mem_busy  out  1  high in MEM_BUS.
- stall  out  6  pipeline stall vector.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  bus address.
- bus_sel  out  4  bus byte enables.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data.
- bus_ack  in  1  bus acknowledge.
- bus_err_o  out  1  MEM access timeout pulse.

Behaviour:
- States: IDLE, IF_BUS, IF_DRAIN, MEM_BUS, MEM_DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All bus_* outputs 0; mem_rdata=0; if_inst=0.
  - Buffer valid=0, tag=0; timeout counter=0; bus_err_o=0.
- bus_* outputs are registered and held stable from bus_req rise until the cycle bus_ack=1.
- bus_req deasserts on the edge after ack.
- bus_ack is ignored in IDLE and MEM_DONE.
- IDLE, priority order:
  - flush=1: stay in IDLE, clear the buffer.
  - mem_ce=1: latch mem_* onto bus_*, bus_req=1 -> MEM_BUS.
  - if_ce=1 and no buffer hit: bus_we=0, bus_sel=4'hF, bus_addr=if_addr -> IF_BUS.
- MEM_BUS:
  - On ack: mem_rdata<=bus_rdata (loads; unchanged for stores) -> MEM_DONE.
  - The counter increments every cycle without ack. When it equals MEM_TIMEOUT, bus_err_o pulses 1 cycle and the counter saturates.
- MEM_DONE: one cycle, mem_ce stall released, then -> IDLE. A back-to-back mem_ce is taken from IDLE on the following cycle.
  - Minimum MEM latency: request cycle N, bus_req from N+1, ack at M, stall released in M+1.
- IF_BUS:
  - On ack: buffer<=bus_rdata, tag<=bus_addr, valid=1 -> IDLE.
  - flush=1 before ack -> IF_DRAIN.
- IF_DRAIN: on ack discard data, buffer stays invalid -> IDLE.
- Buffer hit = valid & (tag==if_addr); if_inst = buffer data.
- Buffer invalidated:
  - at any clock edge where a hit exists, if_ce=1 and stall[1]=0 (instruction consumed);
  - on flush in any state except MEM_BUS.
- Stall requests:
  - stallreq_mem = mem_ce & ~(state==MEM_DONE).
  - stallreq_if = if_ce & ~hit.
- stall vector, combinational, first match wins:
  - flush -> 6'b000000.
  - stallreq_mem -> 6'b011111.
  - stallreq_ex -> 6'b001111.
  - stallreq_id -> 6'b000111.
  - stallreq_if -> 6'b000111.
  - else 6'b000000.
- Interface rule: flush is never asserted while mem_busy=1. The bench checks this as an assertion.
- Reset mid-access: immediate return to IDLE with bus_req=0. Any later ack from the aborted access is ignored in IDLE.
- Simultaneous if_ce and mem_ce in IDLE: MEM is served first, IF is served after MEM_DONE.

Test Plan:
- Reset sequence: rst low with if_ce=1 -> stall=000000 during reset, bus_req=0. After release, if_ce=1 -> bus_req=1 next cycle, bus_addr=if_addr, stall=000111 until ack.
- Fetch 0x00000100, bus ack after 3 wait cycles, data 0x3C010001 -> if_inst=0x3C010001 and stall=000000 the cycle after ack. Buffer invalidated at the next edge.
- if_ce and mem_ce both high, load at 0x80, ack data 0xDEADBEEF:
  - MEM first, stall=011111 through ack;
  - mem_rdata=0xDEADBEEF in MEM_DONE with stall released;
  - the IF access starts two cycles after ack.
- Fetch completes while stallreq_ex=1 for 4 cycles -> instruction held in buffer with no second bus access. if_inst is stable and delivered when stall[1] drops.
- flush pulse during IF_BUS:
  - state -> IF_DRAIN, stall=000000 that cycle;
  - acked data discarded, buffer invalid, fetch of the new if_addr issued afterward.
- MEM_TIMEOUT=4 with no ack for 6 cycles -> bus_err_o pulses once at the 4th wait cycle. A later ack completes the access normally.
